// File: rtl/mont_pkg.sv
// mont_pkg: shared types and sizing helpers for mont_exp_accumulator.
//   mont_state_e  - controller state encoding
//   num_blocks()  - number of REGISTER_SIZE words in a BITS_IN_NUM-bit accumulator
//   Def*          - default sizing, including the derived default block count
package mont_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFetch,
    StIssue,
    StSkip,
    StDrain,
    StOutput
  } mont_state_e;

  function automatic int unsigned num_blocks(input int unsigned bits,
                                             input int unsigned reg_size);
    return bits / reg_size;
  endfunction

  localparam int unsigned DefRegisterSize = 32;
  localparam int unsigned DefBitsInNum    = 4096;
  localparam int unsigned DefExpBits      = 2048;
  localparam int unsigned DefNumBlocks    = num_blocks(DefBitsInNum, DefRegisterSize);

endpackage

// File: rtl/mont_acc_bank.sv
// mont_acc_bank: ping-pong accumulator storage (two banks of NumBlocks x Width) plus,
// when MONT_EXP_SKIP_ZERO_EN is undefined, a const bank holding R mod N^2.
// Simple dual port: one write port, one read port with a registered output.
//   clk_i, rst_ni            clock, async active-low reset (clears only the read registers)
//   rd_en_i/rd_bank_i/rd_addr_i  read request; data appears on rd_*_o next cycle and holds
//   rd_acc_o                 accumulator word from the selected bank
//   rd_const_o               const word at the same address (const bank builds only)
//   wr_en_i/wr_bank_i/wr_addr_i/wr_data_i  accumulator write
//   wr_const_i               also write wr_data_i into the const bank (const bank builds only)
module mont_acc_bank
  import mont_pkg::*;
#(
  parameter int unsigned Width     = DefRegisterSize,
  parameter int unsigned NumBlocks = DefNumBlocks,
  localparam int unsigned AddrW    = (NumBlocks > 1) ? $clog2(NumBlocks) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rd_en_i,
  input  logic             rd_bank_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_acc_o,
`ifndef MONT_EXP_SKIP_ZERO_EN
  output logic [Width-1:0] rd_const_o,
  input  logic             wr_const_i,
`endif
  input  logic             wr_en_i,
  input  logic             wr_bank_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i
);

  logic [Width-1:0] acc_mem_q [2][NumBlocks];
  logic [Width-1:0] rd_acc_q, rd_acc_d;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) acc_mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
  end

  always_comb begin
    rd_acc_d = rd_acc_q;
    if (rd_en_i) rd_acc_d = acc_mem_q[rd_bank_i][rd_addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_acc_q <= '0;
    else         rd_acc_q <= rd_acc_d;
  end

  assign rd_acc_o = rd_acc_q;

`ifndef MONT_EXP_SKIP_ZERO_EN
  logic [Width-1:0] const_mem_q [NumBlocks];
  logic [Width-1:0] rd_const_q, rd_const_d;

  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_const_i) const_mem_q[wr_addr_i] <= wr_data_i;
  end

  always_comb begin
    rd_const_d = rd_const_q;
    if (rd_en_i) rd_const_d = const_mem_q[rd_addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_const_q <= '0;
    else         rd_const_q <= rd_const_d;
  end

  assign rd_const_o = rd_const_q;
`endif

endmodule

// File: rtl/mont_exp_accumulator.sv
// mont_exp_accumulator: right-to-left square-and-multiply accumulator in the Montgomery
// domain. For each exponent bit (LSB first) one square block-train x^(2^i)*R mod N^2 is
// consumed; word pairs go to an external multiply-reduce pipeline whose results are
// written into the other ping-pong bank. Finally the accumulator is streamed out.
// Config macro: MONT_EXP_SKIP_ZERO_EN - zero bits just drop their square train (SKIP);
//   when undefined, zero bits multiply by the stored R mod N^2 (constant time).
// Ports:
//   clk_in, rst_n_in                clock, async active-low reset
//   start_in                        run start pulse (IDLE only)
//   init_valid_in/init_data_in      R mod N^2 words, LSW first
//   exp_valid_in/exp_bit_in/exp_ready_out   exponent bits, LSB first
//   sq_valid_in/sq_data_in/sq_ready_out     square word stream, LSW first
//   mm_valid_out/mm_a_out/mm_b_out/mm_ready_in  operand pairs to multiply-reduce
//   res_valid_in/res_data_in        reduced results, LSW first, no backpressure
//   valid_out/data_out/last_out/ready_in    final accumulator stream
//   busy_out                        high outside IDLE
//   err_out                         sticky: result arrived outside ISSUE/DRAIN
module mont_exp_accumulator
  import mont_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = DefRegisterSize,
  parameter int unsigned BITS_IN_NUM   = DefBitsInNum,
  parameter int unsigned EXP_BITS      = DefExpBits
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  input  logic                     init_valid_in,
  input  logic [REGISTER_SIZE-1:0] init_data_in,
  input  logic                     exp_valid_in,
  input  logic                     exp_bit_in,
  output logic                     exp_ready_out,
  input  logic                     sq_valid_in,
  input  logic [REGISTER_SIZE-1:0] sq_data_in,
  output logic                     sq_ready_out,
  output logic                     mm_valid_out,
  output logic [REGISTER_SIZE-1:0] mm_a_out,
  output logic [REGISTER_SIZE-1:0] mm_b_out,
  input  logic                     mm_ready_in,
  input  logic                     res_valid_in,
  input  logic [REGISTER_SIZE-1:0] res_data_in,
  output logic                     valid_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     last_out,
  input  logic                     ready_in,
  output logic                     busy_out,
  output logic                     err_out
);

  localparam int unsigned NumBlocks = num_blocks(BITS_IN_NUM, REGISTER_SIZE);
  localparam int unsigned AddrW     = (NumBlocks > 1) ? $clog2(NumBlocks) : 1;
  localparam int unsigned CntW      = $clog2(NumBlocks + 1);
  localparam int unsigned BitW      = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [CntW-1:0] LastBlk = CntW'(NumBlocks - 1);
  localparam logic [CntW-1:0] AllBlk  = CntW'(NumBlocks);
  localparam logic [BitW-1:0] LastBit = BitW'(EXP_BITS - 1);

  mont_state_e              state_q, state_d;
  logic                     cur_bank_q, cur_bank_d;
  logic                     cur_bit_q, cur_bit_d;
  logic [CntW-1:0]          blk_idx_q, blk_idx_d;
  logic [CntW-1:0]          res_idx_q, res_idx_d;
  logic [BitW-1:0]          bit_idx_q, bit_idx_d;
  logic                     mm_valid_q, mm_valid_d;
  logic [REGISTER_SIZE-1:0] mm_b_q, mm_b_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     err_q, err_d;

  logic                     rd_en, rd_bank, wr_en, wr_bank;
  logic [AddrW-1:0]         rd_addr, wr_addr;
  logic [REGISTER_SIZE-1:0] wr_data, rd_acc;
  logic [CntW-1:0]          blk_next;
  logic                     sq_accept;
`ifndef MONT_EXP_SKIP_ZERO_EN
  logic                     wr_const;
  logic [REGISTER_SIZE-1:0] rd_const;
`endif

  always_comb begin
    sq_ready_out = 1'b0;
    if (state_q == StIssue) sq_ready_out = !mm_valid_q || mm_ready_in;
`ifdef MONT_EXP_SKIP_ZERO_EN
    if (state_q == StSkip) sq_ready_out = 1'b1;
`endif
  end

  assign sq_accept = sq_valid_in && sq_ready_out;
  assign blk_next  = blk_idx_q + CntW'(1);

  always_comb begin
    state_d    = state_q;
    cur_bank_d = cur_bank_q;
    cur_bit_d  = cur_bit_q;
    blk_idx_d  = blk_idx_q;
    res_idx_d  = res_idx_q;
    bit_idx_d  = bit_idx_q;
    mm_valid_d = mm_valid_q;
    mm_b_d     = mm_b_q;
    valid_d    = valid_q;
    last_d     = last_q;
    err_d      = err_q;
    rd_en      = 1'b0;
    rd_bank    = cur_bank_q;
    rd_addr    = blk_idx_q[AddrW-1:0];
    wr_en      = 1'b0;
    wr_bank    = !cur_bank_q;
    wr_addr    = res_idx_q[AddrW-1:0];
    wr_data    = res_data_in;
`ifndef MONT_EXP_SKIP_ZERO_EN
    wr_const   = 1'b0;
`endif

    // A pair leaves on handshake; a new accept below re-arms it in the same cycle.
    if (mm_ready_in) mm_valid_d = 1'b0;

    // Results land in the bank being built, in order, with no backpressure.
    if (res_valid_in) begin
      if (state_q == StIssue || state_q == StDrain) begin
        if (res_idx_q != AllBlk) begin
          wr_en     = 1'b1;
          res_idx_d = res_idx_q + CntW'(1);
        end
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d    = StLoad;
          cur_bank_d = 1'b0;
          blk_idx_d  = '0;
          res_idx_d  = '0;
          bit_idx_d  = '0;
        end
      end
      StLoad: begin
        if (init_valid_in) begin
          wr_en   = 1'b1;
          wr_bank = 1'b0;
          wr_addr = blk_idx_q[AddrW-1:0];
          wr_data = init_data_in;
`ifndef MONT_EXP_SKIP_ZERO_EN
          wr_const = 1'b1;
`endif
          if (blk_idx_q == LastBlk) begin
            blk_idx_d = '0;
            state_d   = StFetch;
          end else begin
            blk_idx_d = blk_next;
          end
        end
      end
      StFetch: begin
        if (exp_valid_in) begin
          cur_bit_d = exp_bit_in;
`ifdef MONT_EXP_SKIP_ZERO_EN
          state_d   = exp_bit_in ? StIssue : StSkip;
`else
          state_d   = StIssue;
`endif
        end
      end
      StIssue: begin
        if (sq_accept) begin
          // The bank read register becomes mm_a_out next cycle, aligned with mm_valid.
          rd_en      = 1'b1;
          mm_valid_d = 1'b1;
          if (cur_bit_q) mm_b_d = sq_data_in;
          if (blk_idx_q == LastBlk) begin
            blk_idx_d = '0;
            state_d   = StDrain;
          end else begin
            blk_idx_d = blk_next;
          end
        end
      end
      StDrain: begin
        if (res_idx_q == AllBlk) begin
          cur_bank_d = !cur_bank_q;
          res_idx_d  = '0;
          if (bit_idx_q == LastBit) begin
            bit_idx_d = '0;
            state_d   = StOutput;
          end else begin
            bit_idx_d = bit_idx_q + BitW'(1);
            state_d   = StFetch;
          end
        end
      end
`ifdef MONT_EXP_SKIP_ZERO_EN
      StSkip: begin
        if (sq_accept) begin
          if (blk_idx_q == LastBlk) begin
            blk_idx_d = '0;
            if (bit_idx_q == LastBit) begin
              bit_idx_d = '0;
              state_d   = StOutput;
            end else begin
              bit_idx_d = bit_idx_q + BitW'(1);
              state_d   = StFetch;
            end
          end else begin
            blk_idx_d = blk_next;
          end
        end
      end
`endif
      StOutput: begin
        if (!valid_q) begin
          // One-cycle bubble to prefetch word 0 through the registered read.
          rd_en   = 1'b1;
          valid_d = 1'b1;
          last_d  = (blk_idx_q == LastBlk);
        end else if (ready_in) begin
          if (last_q) begin
            valid_d   = 1'b0;
            last_d    = 1'b0;
            blk_idx_d = '0;
            state_d   = StIdle;
          end else begin
            blk_idx_d = blk_next;
            rd_en     = 1'b1;
            rd_addr   = blk_next[AddrW-1:0];
            last_d    = (blk_next == LastBlk);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      cur_bank_q <= 1'b0;
      cur_bit_q  <= 1'b0;
      blk_idx_q  <= '0;
      res_idx_q  <= '0;
      bit_idx_q  <= '0;
      mm_valid_q <= 1'b0;
      mm_b_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_bank_q <= cur_bank_d;
      cur_bit_q  <= cur_bit_d;
      blk_idx_q  <= blk_idx_d;
      res_idx_q  <= res_idx_d;
      bit_idx_q  <= bit_idx_d;
      mm_valid_q <= mm_valid_d;
      mm_b_q     <= mm_b_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  mont_acc_bank #(
    .Width     (REGISTER_SIZE),
    .NumBlocks (NumBlocks)
  ) u_bank (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .rd_en_i    (rd_en),
    .rd_bank_i  (rd_bank),
    .rd_addr_i  (rd_addr),
    .rd_acc_o   (rd_acc),
`ifndef MONT_EXP_SKIP_ZERO_EN
    .rd_const_o (rd_const),
    .wr_const_i (wr_const),
`endif
    .wr_en_i    (wr_en),
    .wr_bank_i  (wr_bank),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data)
  );

  assign exp_ready_out = (state_q == StFetch);
  assign busy_out      = (state_q != StIdle);
  assign mm_valid_out  = mm_valid_q;
  assign mm_a_out      = rd_acc;
`ifdef MONT_EXP_SKIP_ZERO_EN
  assign mm_b_out      = mm_b_q;
`else
  // Zero bits use the const word read alongside the accumulator word.
  assign mm_b_out      = cur_bit_q ? mm_b_q : rd_const;
`endif
  assign valid_out     = valid_q;
  assign data_out      = rd_acc;
  assign last_out      = last_q;
  assign err_out       = err_q;

endmodule

// File: tb/tb_mont_exp_accumulator.sv
// Bench for mont_exp_accumulator with REGISTER_SIZE=8, NUM_BLOCKS=4, EXP_BITS=4.
// Each word lane is an independent 8-bit Montgomery exponentiation mod N^2=0xF1
// (R = 256 mod 241 = 15, R^-1 = 225). Expected words come from plain modexp.
module tb_mont_exp_accumulator;

  localparam int unsigned RS  = 8;
  localparam int unsigned NB  = 4;
  localparam int          MOD = 241;
  localparam logic [7:0]  RMONT = 8'd15;
  localparam logic [31:0] XA = {8'd2, 8'd7, 8'd5, 8'd3};
  localparam logic [31:0] XB = {8'd99, 8'd17, 8'd200, 8'd10};
  localparam logic [31:0] XC = {8'd13, 8'd11, 8'd6, 8'd4};

  logic          clk_in, rst_n_in, start_in;
  logic          init_valid_in, exp_valid_in, exp_bit_in, exp_ready_out;
  logic [RS-1:0] init_data_in, sq_data_in, mm_a_out, mm_b_out, res_data_in, data_out;
  logic          sq_valid_in, sq_ready_out, mm_valid_out, mm_ready_in, res_valid_in;
  logic          valid_out, last_out, ready_in, busy_out, err_out;

  int            errors = 0;
  int            checks = 0;
  int            pairs = 0;
  int            inject_req = 0;
  int            inject_done = 0;
  bit            toggle_mode = 0;
  logic [7:0]    exp_q [$];

  mont_exp_accumulator #(
    .REGISTER_SIZE (8),
    .BITS_IN_NUM   (32),
    .EXP_BITS      (4)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .start_in      (start_in),
    .init_valid_in (init_valid_in),
    .init_data_in  (init_data_in),
    .exp_valid_in  (exp_valid_in),
    .exp_bit_in    (exp_bit_in),
    .exp_ready_out (exp_ready_out),
    .sq_valid_in   (sq_valid_in),
    .sq_data_in    (sq_data_in),
    .sq_ready_out  (sq_ready_out),
    .mm_valid_out  (mm_valid_out),
    .mm_a_out      (mm_a_out),
    .mm_b_out      (mm_b_out),
    .mm_ready_in   (mm_ready_in),
    .res_valid_in  (res_valid_in),
    .res_data_in   (res_data_in),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .last_out      (last_out),
    .ready_in      (ready_in),
    .busy_out      (busy_out),
    .err_out       (err_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int modpow(input int b, input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = (r * b) % MOD;
    return r;
  endfunction

  function automatic logic [7:0] to_mont(input int v);
    return 8'((v * 15) % MOD);
  endfunction

  function automatic logic [7:0] montmul(input logic [7:0] a, input logic [7:0] b);
    return 8'((int'(a) * int'(b) * 225) % MOD);
  endfunction

  // Multiply-reduce model: 3-cycle latency, in order, optional ready toggling.
  initial begin
    bit         pv [3];
    logic [7:0] pd [3];
    for (int k = 0; k < 3; k++) begin pv[k] = 0; pd[k] = '0; end
    res_valid_in = 1'b0;
    res_data_in  = '0;
    mm_ready_in  = 1'b1;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        for (int k = 0; k < 3; k++) pv[k] = 0;
        res_valid_in = 1'b0;
      end else begin
        res_valid_in = pv[2];
        res_data_in  = pd[2];
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = 0;
        if (inject_req != inject_done) begin
          res_valid_in = 1'b1;
          res_data_in  = 8'hAA;
          inject_done++;
        end
        mm_ready_in = toggle_mode ? !mm_ready_in : 1'b1;
        #1;
        if (mm_valid_out && mm_ready_in) begin
          pv[0] = 1;
          pd[0] = montmul(mm_a_out, mm_b_out);
          pairs++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_and_load();
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int j = 0; j < NB; j++) begin
      init_valid_in = 1'b1;
      init_data_in  = RMONT;
      @(negedge clk_in);
    end
    init_valid_in = 1'b0;
  endtask

  task automatic send_exp(input logic b);
    int n = 0;
    exp_valid_in = 1'b1;
    exp_bit_in   = b;
    #1;
    while (!exp_ready_out && n < 200) begin @(negedge clk_in); #1; n++; end
    check("exp_handshake", {31'd0, exp_ready_out}, 32'd1);
    @(negedge clk_in);
    exp_valid_in = 1'b0;
  endtask

  task automatic send_sq(input logic [7:0] w);
    int n = 0;
    sq_valid_in = 1'b1;
    sq_data_in  = w;
    #1;
    while (!sq_ready_out && n < 200) begin @(negedge clk_in); #1; n++; end
    check("sq_handshake", {31'd0, sq_ready_out}, 32'd1);
    @(negedge clk_in);
    sq_valid_in = 1'b0;
  endtask

  task automatic collect(input string name, input bit stall);
    int n;
    logic [7:0] w;
    ready_in = 1'b1;
    #1;
    for (int j = 0; j < NB; j++) begin
      n = 0;
      while (!valid_out && n < 100) begin @(negedge clk_in); #1; n++; end
      check({name, "_valid"}, {31'd0, valid_out}, 32'd1);
      if (stall && j == 1) begin
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_in); #1;
          check({name, "_stall_valid"}, {31'd0, valid_out}, 32'd1);
          check({name, "_stall_data"}, {24'd0, data_out}, {24'd0, exp_q[0]});
        end
        ready_in = 1'b1;
      end
      w = exp_q.pop_front();
      check({name, "_data"}, {24'd0, data_out}, {24'd0, w});
      check({name, "_last"}, {31'd0, last_out}, {31'd0, (j == NB - 1)});
      @(negedge clk_in); #1;
    end
    check({name, "_idle"}, {30'd0, busy_out, valid_out}, 32'd0);
  endtask

  task automatic run_exp(input string name, input logic [3:0] e, input logic [31:0] xv,
                         input bit stall, input bit inject);
    int p0 = pairs;
    int exp_pairs;
`ifdef MONT_EXP_SKIP_ZERO_EN
    exp_pairs = $countones(e) * NB;
`else
    exp_pairs = 4 * NB;
`endif
    for (int j = 0; j < NB; j++) exp_q.push_back(to_mont(modpow(int'(xv[8*j +: 8]), int'(e))));
    start_and_load();
    if (inject) begin
      inject_req++;
      repeat (3) @(negedge clk_in);
      #1;
      check({name, "_err_set"}, {31'd0, err_out}, 32'd1);
      @(negedge clk_in);
    end
    for (int i = 0; i < 4; i++) begin
      send_exp(e[i]);
      for (int j = 0; j < NB; j++) send_sq(to_mont(modpow(int'(xv[8*j +: 8]), 1 << i)));
    end
    collect(name, stall);
    check({name, "_pairs"}, 32'(pairs - p0), 32'(exp_pairs));
  endtask

  task automatic abort_run(input logic [31:0] xv);
    start_and_load();
    send_exp(1'b1);
    for (int j = 0; j < NB; j++) send_sq(to_mont(int'(xv[8*j +: 8])));
    check("abort_busy", {31'd0, busy_out}, 32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    check("abort_ctrl", {25'd0, exp_ready_out, sq_ready_out, mm_valid_out, valid_out,
                         last_out, busy_out, err_out}, 32'd0);
    check("abort_data", {8'd0, mm_a_out, mm_b_out, data_out}, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    #2 rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    rst_n_in      = 1'b0;
    start_in      = 1'b0;
    init_valid_in = 1'b0;
    init_data_in  = '0;
    exp_valid_in  = 1'b0;
    exp_bit_in    = 1'b0;
    sq_valid_in   = 1'b0;
    sq_data_in    = '0;
    ready_in      = 1'b1;
    #12;
    check("reset_ctrl", {25'd0, exp_ready_out, sq_ready_out, mm_valid_out, valid_out,
                         last_out, busy_out, err_out}, 32'd0);
    check("reset_data", {8'd0, mm_a_out, mm_b_out, data_out}, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    run_exp("a_1011", 4'b1011, XA, 1'b0, 1'b0);
    check("a_err_clear", {31'd0, err_out}, 32'd0);
    run_exp("b_0000", 4'b0000, XB, 1'b0, 1'b0);
    toggle_mode = 1'b1;
    run_exp("c_toggle", 4'b1011, XA, 1'b0, 1'b0);
    toggle_mode = 1'b0;
    run_exp("d_stall", 4'b0110, XB, 1'b1, 1'b0);
    abort_run(XC);
    run_exp("e_after_rst", 4'b1101, XC, 1'b0, 1'b0);
    check("e_err_clear", {31'd0, err_out}, 32'd0);
    run_exp("f_err", 4'b1011, XA, 1'b0, 1'b1);
    check("f_err_sticky", {31'd0, err_out}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
